// File: rtl/multiplier_booth_ctrl.sv
// Sequential radix-2 Booth multiplier (32x32 signed -> low word + overflow), one iteration per cycle.
// Latency 33 cycles start-to-ready; no backpressure, a new start aborts any multiply in flight.

module multiplier_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sel0,   // 1: a+b, 0: a-b
  input  logic             i_sel1,   // 0: pass a through
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_sum_ext;

  always_comb begin
    w_b_op    = i_sel0 ? i_b : ~i_b;
    w_sum_ext = {1'b0, i_a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, ~i_sel0};
    if (i_sel1) begin
      o_sum  = w_sum_ext[WIDTH-1:0];
      o_cout = w_sum_ext[WIDTH];
    end else begin
      o_sum  = i_a;
      o_cout = 1'b0;
    end
  end
endmodule

module multiplier_booth_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_m, r_q, r_result;
  logic [WIDTH:0]   r_acc;
  logic             r_q1, r_exc, r_rdy;
  logic [CW-1:0]    r_cnt;

  logic             w_sel0, w_sel1, w_cout, w_guard;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_acc_new;

  multiplier_adder #(.WIDTH(WIDTH)) u_adder (
    .i_a    (r_acc[WIDTH-1:0]),
    .i_b    (r_m),
    .i_sel0 (w_sel0),
    .i_sel1 (w_sel1),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Guard bit reconstructs the 33rd sum bit so M = most-negative stays exact.
  always_comb begin
    w_sel1    = r_q[0] ^ r_q1;
    w_sel0    = ~r_q[0];
    w_guard   = r_acc[WIDTH] ^ (w_sel0 ? r_m[WIDTH-1] : ~r_m[WIDTH-1]) ^ w_cout;
    w_acc_new = w_sel1 ? {w_guard, w_sum} : r_acc;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (ctrl_MULT) w_state_nxt = S_RUN;
      S_RUN: begin
        if (ctrl_MULT)                         w_state_nxt = S_RUN;
        else if (r_cnt == CW'(ITER - 1))       w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = ctrl_MULT ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_m      <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_q1     <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_result <= r_q;
        r_exc    <= (r_acc[WIDTH-1:0] != {WIDTH{r_q[WIDTH-1]}});
      end
      if (ctrl_MULT) begin
        r_m   <= data_operandA;
        r_acc <= '0;
        r_q   <= data_operandB;
        r_q1  <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_acc <= {w_acc_new[WIDTH], w_acc_new[WIDTH:1]};
        r_q   <= {w_acc_new[0], r_q[WIDTH-1:1]};
        r_q1  <= r_q[0];
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = (r_state == S_RUN);
endmodule

// File: tb/tb_multiplier_booth_ctrl.sv
// Randomized and directed bench for multiplier_booth_ctrl against a 64-bit arithmetic product model.
module tb_multiplier_booth_ctrl;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  multiplier_booth_ctrl #(.WIDTH(32), .ITER(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_lo(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [31:0] lo;
    p  = longint'($signed(a)) * longint'($signed(b));
    lo = p[31:0];
    return p != longint'($signed(lo));
  endfunction

  // Drive a start pulse; the rising edge inside this task is "edge 0".
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
  endtask

  task automatic wait_rdy(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    start(a, b);
    chk({tag, " busy"}, 64'(busy), 64'd1);
    wait_rdy(cyc);
    chk({tag, " latency"}, 64'(cyc), 64'd33);
    chk({tag, " result"}, 64'(data_result), 64'(ref_lo(a, b)));
    chk({tag, " exc"}, 64'(data_exception), 64'(ref_ovf(a, b)));
    @(posedge clock);
    #1;
    chk({tag, " rdy pulse"}, 64'(data_resultRDY), 64'd0);
    chk({tag, " idle"}, 64'(busy), 64'd0);
    chk({tag, " hold"}, 64'(data_result), 64'(ref_lo(a, b)));
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int seen;
    logic [31:0] a, b;

    repeat (2) @(posedge clock);
    #1;
    chk("reset result", 64'(data_result), 64'd0);
    chk("reset exc", 64'(data_exception), 64'd0);
    chk("reset rdy", 64'(data_resultRDY), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    run_op("3x5", 32'd3, 32'd5);
    chk("3x5 value", 64'(data_result), 64'd15);
    run_op("-7x6", 32'hFFFF_FFF9, 32'd6);
    chk("-7x6 value", 64'(data_result), 64'hFFFF_FFD6);
    run_op("min x 1", 32'h8000_0000, 32'd1);
    run_op("min x -1", 32'h8000_0000, 32'hFFFF_FFFF);
    chk("min x -1 exc", 64'(data_exception), 64'd1);
    run_op("2^16 sq", 32'h0001_0000, 32'h0001_0000);
    chk("2^16 sq exc", 64'(data_exception), 64'd1);
    run_op("min x min", 32'h8000_0000, 32'h8000_0000);
    run_op("max x min", 32'h7FFF_FFFF, 32'h8000_0000);
    run_op("0 x -1", 32'd0, 32'hFFFF_FFFF);

    // Abort: restart 10 cycles into a run; only the second op may complete.
    start(32'd100, 32'd100);
    seen = 0;
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen++;
    end
    start(32'd7, 32'd8);
    wait_rdy(cyc);
    chk("abort early rdy", 64'(seen), 64'd0);
    chk("abort latency", 64'(cyc), 64'd33);
    chk("abort result", 64'(data_result), 64'd56);

    // Asynchronous reset mid-run: outputs clear before the next edge, no rdy afterwards.
    start(32'd12, 32'd12);
    repeat (19) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst result", 64'(data_result), 64'd0);
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst rdy", 64'(data_resultRDY), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen++;
    end
    chk("arst no rdy", 64'(seen), 64'd0);
    run_op("2x2 after rst", 32'd2, 32'd2);
    chk("2x2 value", 64'(data_result), 64'd4);

    // Back-to-back: second start sampled on the DONE edge of the first.
    start(32'd9, 32'd9);
    repeat (32) @(posedge clock);
    #1;
    ctrl_MULT     = 1'b1;
    data_operandA = 32'hFFFF_FFFD;
    data_operandB = 32'd1000;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    chk("b2b first rdy", 64'(data_resultRDY), 64'd1);
    chk("b2b first result", 64'(data_result), 64'd81);
    chk("b2b busy", 64'(busy), 64'd1);
    wait_rdy(cyc);
    chk("b2b second latency", 64'(cyc), 64'd33);
    chk("b2b second result", 64'(data_result), 64'(ref_lo(32'hFFFF_FFFD, 32'd1000)));

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 1) a = $signed(16'($urandom));
      if (i % 3 == 2) b = $signed(16'($urandom));
      run_op($sformatf("rand%0d", i), a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/multiplier_booth_ctrl.md
Name: multiplier_booth_ctrl

Overview:
- Sequential radix-2 Booth controller for the 32-bit signed multiplier.
- Owns the partial-product register and the iteration counter. Drives one internal multiplier_adder instance each cycle: add, subtract or pass.
- Sits between the ALU issue logic and the writeback mux. Returns the low 32 bits of the product plus an overflow flag.

Parameters:
WIDTH, 32, operand and result width. Only 32 is supported; it matches the adder.
ITER, 32, Booth iterations per multiply. Must equal WIDTH.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
ctrl_MULT  input  1  start pulse; operands sampled on the same edge
data_operandA  input  32  multiplicand (signed)
data_operandB  input  32  multiplier (signed)
data_result  output  32  low 32 bits of A*B
data_exception  output  1  high if the 64-bit product does not fit in signed 32 bits
data_resultRDY  output  1  one-cycle done pulse
busy  output  1  high while in RUN

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, counter=0, accumulator=0, M=0.
  - All outputs 0.
  - Reset mid-operation abandons the multiply; no resultRDY is issued.
- Registers:
  - M: 32-bit multiplicand.
  - ACC: 33-bit upper accumulator, bit 32 is the sign guard.
  - Q: 32-bit multiplier/low word.
  - q_1: Booth extra bit.
  - cnt: 5 bits.
- IDLE:
  - On ctrl_MULT=1: M<=operandA, ACC<=0, Q<=operandB, q_1<=0, cnt<=0, go to RUN.
- RUN, one iteration per cycle:
  - {Q[0],q_1} = 01 -> adder sel0=1 (add), sel1=1.
  - {Q[0],q_1} = 10 -> sel0=0 (subtract), sel1=1.
  - {Q[0],q_1} = 00 or 11 -> sel1=0 (pass ACC unchanged).
  - Adder inputs: a=ACC[31:0], b=M.
  - New guard bit: ACC[32] XOR b_new_ext XOR cout, where b_new_ext = M[31] for add and ~M[31] for subtract. This makes ACC exact for M = 0x80000000.
  - In the same cycle, arithmetic shift right of {ACC',Q,q_1} by one; ACC[32] is replicated.
  - cnt increments. After the iteration with cnt=31, go to DONE.
- DONE (exactly one cycle):
  - data_resultRDY=1.
  - data_result<=Q.
  - data_exception<=1 unless ACC[31:0] is all copies of Q[31].
  - Then return to IDLE.
- Output holding:
  - data_result and data_exception hold until the next DONE.
  - busy=1 only in RUN.
- Latency: ctrl_MULT sampled at edge 0. resultRDY is high during the cycle after edge 33, i.e. 33 cycles start-to-ready.
- ctrl_MULT while RUN: aborts the current multiply and restarts with the newly sampled operands; cnt returns to 0. No resultRDY for the aborted op.
- ctrl_MULT during DONE: the DONE pulse still occurs, and the new operation is captured on that edge. The next state is RUN, not IDLE.
- The adder is used in one configuration per cycle only. No combinational path from inputs to outputs.

Test Plan:
- reset_n=0 then 1; ctrl_MULT 3 x 5 -> resultRDY 33 cycles after start, data_result=15, exception=0, busy low afterwards.
- -7 (0xFFFFFFF9) x 6 -> data_result=0xFFFFFFD6 (-42), exception=0. Also 0x80000000 x 1 -> 0x80000000, exception=0 (guard-bit case).
- 0x80000000 x 0xFFFFFFFF -> data_result=0x80000000, exception=1. Also 0x00010000 x 0x00010000 -> data_result=0, exception=1.
- Start 100 x 100, reassert ctrl_MULT with 7 x 8 at cycle 10 -> no resultRDY for the first op; a single resultRDY 33 cycles after the second start; data_result=56.
- Start 12 x 12, drop reset_n at cycle 20 for 1 cycle -> outputs 0 immediately (asynchronous); no resultRDY ever. A subsequent 2 x 2 returns 4.
- Back-to-back: ctrl_MULT asserted in the DONE cycle of 9 x 9 -> resultRDY 81, then 33 cycles later the second product is correct.
